// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard for the decode/issue stage: per-register pending-write counters for x1..x31.
// Optional macro SCOREBOARD_BYPASS_EN lets a source read through a same-cycle writeback of its last pending write.
module reg_scoreboard #(
  parameter int CNT_W    = 2,
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                issue_valid,
  input  logic [4:0]          issue_rs1,
  input  logic [4:0]          issue_rs2,
  input  logic                issue_uses_rs1,
  input  logic                issue_uses_rs2,
  input  logic                issue_wr_en,
  input  logic [4:0]          issue_rd,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  output logic                issue_ready,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                err_q, err_d;

  logic rs1_pend, rs2_pend, rs1_byp, rs2_byp, rd_sat, accept, wb_under;

  assign rs1_pend = issue_uses_rs1 && (issue_rs1 != 5'd0) && (cnt_q[issue_rs1] != '0);
  assign rs2_pend = issue_uses_rs2 && (issue_rs2 != 5'd0) && (cnt_q[issue_rs2] != '0);

`ifdef SCOREBOARD_BYPASS_EN
  // The register file writes through, so the final outstanding write landing now satisfies the read.
  assign rs1_byp = wb_valid && (wb_rd == issue_rs1) && (cnt_q[issue_rs1] == CNT_ONE);
  assign rs2_byp = wb_valid && (wb_rd == issue_rs2) && (cnt_q[issue_rs2] == CNT_ONE);
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  assign rd_sat      = issue_wr_en && (issue_rd != 5'd0) && (cnt_q[issue_rd] == CNT_MAX);
  assign issue_ready = !flush && !(rs1_pend && !rs1_byp) && !(rs2_pend && !rs2_byp) && !rd_sat;
  assign accept      = issue_valid && issue_ready;
  assign wb_under    = wb_valid && (wb_rd != 5'd0) && (cnt_q[wb_rd] == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    logic inc, dec;
    busy_d = '0;
    err_d  = err_q | (wb_under && !flush);
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      inc      = accept && issue_wr_en && (issue_rd == 5'(i));
      dec      = wb_valid && (wb_rd == 5'(i)) && (cnt_q[i] != '0);
      if (inc && !dec)      cnt_d[i] = cnt_q[i] + CNT_ONE;
      else if (dec && !inc) cnt_d[i] = cnt_q[i] - CNT_ONE;
      if (flush || i == 0) cnt_d[i] = '0;
      busy_d[i] = (i != 0) && !flush && (cnt_q[i] != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_vec      = busy_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: a reference model pushes expected busy/error state per cycle,
// popped and compared after each clock edge, plus directed checks on the hazard cases.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst, flush, issue_valid, issue_uses_rs1, issue_uses_rs2, issue_wr_en, wb_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic        issue_ready, err_underflow;
  logic [31:0] busy_vec;

  reg_scoreboard dut (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
    .issue_wr_en(issue_wr_en), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue_ready(issue_ready), .busy_vec(busy_vec), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

`ifdef SCOREBOARD_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct packed { logic [31:0] busy; logic err; } exp_t;
  exp_t exp_q[$];

  int   checks = 0, failures = 0;
  int   m_cnt [32];
  logic m_err;
  logic obs_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_err = 1'b0;
    exp_q.delete();
  endtask

  // One clock cycle: drive, check issue_ready mid-cycle, advance the model, compare registered outputs.
  task automatic cyc(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                     input logic u2, input logic we, input logic [4:0] rd,
                     input logic wv, input logic [4:0] wr, input logic fl);
    logic exp_ready, acc;
    exp_t e;
    issue_valid = v; issue_rs1 = r1; issue_uses_rs1 = u1; issue_rs2 = r2; issue_uses_rs2 = u2;
    issue_wr_en = we; issue_rd = rd; wb_valid = wv; wb_rd = wr; flush = fl;
    @(negedge clk);
    exp_ready = !fl;
    if (u1 && r1 != 0 && m_cnt[r1] != 0 && !(BYP && wv && wr == r1 && m_cnt[r1] == 1)) exp_ready = 1'b0;
    if (u2 && r2 != 0 && m_cnt[r2] != 0 && !(BYP && wv && wr == r2 && m_cnt[r2] == 1)) exp_ready = 1'b0;
    if (we && rd != 0 && m_cnt[rd] == 3) exp_ready = 1'b0;
    obs_ready = issue_ready;
    check("issue_ready", 32'(issue_ready), 32'(exp_ready));
    acc = v && exp_ready;
    e.busy = '0;
    for (int i = 1; i < 32; i++) e.busy[i] = !fl && (m_cnt[i] != 0);
    if (!fl && wv && wr != 0 && m_cnt[wr] == 0) m_err = 1'b1;
    e.err = m_err;
    exp_q.push_back(e);
    if (fl) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else begin
      if (wv && wr != 0 && m_cnt[wr] != 0) m_cnt[wr]--;
      if (acc && we && rd != 0) m_cnt[rd]++;
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("busy_vec", busy_vec, e.busy);
    check("err_underflow", 32'(err_underflow), 32'(e.err));
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 0; issue_valid = 0; issue_uses_rs1 = 0; issue_uses_rs2 = 0;
    issue_wr_en = 0; wb_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; wb_rd = 0;
    model_reset();
    #3;
    check("reset_ready", 32'(issue_ready), 32'd1);
    check("reset_busy", busy_vec, 32'h0);
    check("reset_err", 32'(err_underflow), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // RAW stall and release on x5
    cyc(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    idle();
    check("busy_x5", busy_vec, 32'h20);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    check("raw_stall", 32'(obs_ready), 32'd0);
    cyc(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    check("raw_release", 32'(obs_ready), 32'd1);
    idle();
    check("busy_clear", busy_vec, 32'h0);

    // x0 is never tracked
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    check("x0_ready", 32'(obs_ready), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    check("x0_busy", busy_vec, 32'h0);
    check("x0_no_err", 32'(err_underflow), 32'd0);

    // WAW accumulation and saturation on x7
    repeat (3) cyc(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    check("sat_stall", 32'(obs_ready), 32'd0);
    cyc(1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
    check("sat_no_bypass", 32'(obs_ready), 32'd0);
    cyc(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    check("sat_accept", 32'(obs_ready), 32'd1);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
    idle();
    check("busy7_held", 32'(busy_vec[7]), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
    idle();
    check("busy7_clear", 32'(busy_vec[7]), 32'd0);

    // Simultaneous issue and writeback on x9
    cyc(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 9, 1, 9, 0);
    idle(); idle();
    check("busy9_kept", 32'(busy_vec[9]), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);

    // Same-cycle writeback read of x3
    cyc(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    cyc(1, 0, 0, 3, 1, 0, 0, 1, 3, 0);
    check("bypass_rs2", 32'(obs_ready), 32'(BYP));
    idle();

    // Underflow is sticky across flush
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
    check("underflow_set", 32'(err_underflow), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("underflow_sticky", 32'(err_underflow), 32'd1);

    // Flush with pending x4/x8, a same-cycle issue and writeback
    cyc(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    idle();
    check("busy_4_8", busy_vec, 32'h110);
    cyc(1, 0, 0, 0, 0, 1, 10, 1, 4, 1);
    check("flush_ready", 32'(obs_ready), 32'd0);
    check("flush_busy", busy_vec, 32'h0);
    idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    check("flush_cleared_x4", 32'(err_underflow), 32'd1);

    // Asynchronous reset mid-operation with x20 pending twice
    repeat (2) cyc(1, 0, 0, 0, 0, 1, 20, 0, 0, 0);
    idle();
    check("busy20", busy_vec, 32'h0010_0000);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy_vec, 32'h0);
    check("arst_err", 32'(err_underflow), 32'd0);
    check("arst_ready", 32'(issue_ready), 32'd1);
    model_reset();
    @(posedge clk); #1; rst = 1'b0;
    cyc(1, 20, 1, 0, 0, 0, 0, 0, 0, 0);
    check("arst_x20_free", 32'(obs_ready), 32'd1);
    idle();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register-hazard scoreboard that sits directly upstream of the register-file read ports, in the decode/issue stage.
- Tracks which architectural registers x1..x31 have writes in flight between issue and writeback.
- Deasserts issue_ready when an instruction would read a pending register (RAW hazard) or would overflow a register's pending-write counter.
- x0 is never tracked and never stalls.

Parameters:
- CNT_W, 2: width of each per-register pending-write counter. Maximum outstanding writes per register is MAX = 2^CNT_W - 1.
- NUM_REGS, 32: number of architectural registers. Register 0 is hardwired zero.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  clears all pending state; has priority over every other event
- issue_valid  input  1  the instruction in decode requests issue
- issue_rs1  input  5  source register 1 index
- issue_rs2  input  5  source register 2 index
- issue_uses_rs1  input  1  the instruction reads rs1
- issue_uses_rs2  input  1  the instruction reads rs2
- issue_wr_en  input  1  the instruction writes rd
- issue_rd  input  5  destination register index
- wb_valid  input  1  a writeback to the register file completes this cycle
- wb_rd  input  5  writeback destination index
- issue_ready  output  1  combinational; high means no hazard, so the issue is accepted if issue_valid is high
- busy_vec  output  32  registered; bit i = (cnt[i] != 0); bit 0 is always 0
- err_underflow  output  1  registered, sticky; set on a writeback to a register with no pending write

Behaviour:
- Reset (rst=1, asynchronous): all cnt[i]=0, busy_vec=0, err_underflow=0. During reset, issue_ready evaluates combinationally to 1 when the scoreboard is empty.
- Source hazard for rsN: issue_uses_rsN && rsN!=0 && cnt[rsN]!=0.
- Destination saturation: issue_wr_en && issue_rd!=0 && cnt[issue_rd]==MAX.
- issue_ready = !flush && no source hazard && no destination saturation.
- issue_ready does not depend on issue_valid.
- accept = issue_valid && issue_ready.
- Per-register update each cycle, for i in 1..31:
  - inc = accept && issue_wr_en && issue_rd==i
  - dec = wb_valid && wb_rd==i && cnt[i]!=0
  - inc && dec: cnt unchanged.
  - inc only: cnt+1. Saturation is prevented by issue_ready.
  - dec only: cnt-1.
- Underflow: wb_valid && wb_rd!=0 && cnt[wb_rd]==0 sets err_underflow on the next edge. cnt stays 0.
- err_underflow clears only on reset.
- wb_rd==0 and issue_rd==0 are ignored entirely: no count change, no error.
- Flush: on the next edge all cnt=0 and busy_vec=0.
  - Same-cycle issue is not recorded, since issue_ready=0.
  - Same-cycle writeback is ignored and raises no underflow.
  - err_underflow is preserved.
- WAW is allowed: repeated issues to the same rd accumulate up to MAX. The register stays busy until the count returns to 0.
- Reset mid-operation discards all pending state immediately.
- busy_vec updates with one-cycle latency after the edge that changes cnt.

Optional Feature:
- Macro: SCOREBOARD_BYPASS_EN.
- Defined:
  - A source is also not hazardous when wb_valid && wb_rd==rsN && cnt[rsN]==1 in the same cycle. This matches the register file's write-through behaviour on same-cycle write/read.
  - The bypass does not relax destination saturation.
- Undefined:
  - The source remains hazardous in the writeback cycle.
  - Issue proceeds one cycle later.

Test Plan:
- Basic RAW stall and release:
  - Reset. Issue wr_en rd=5 → cnt[5]=1, busy_vec=0x20.
  - Next instruction reads rs1=5 → issue_ready=0.
  - wb_rd=5 → next cycle issue_ready=1, busy_vec=0.
- x0 handling:
  - Issue wr_en rd=0, then read rs1=0, rs2=0 → issue_ready=1 throughout, busy_vec=0.
  - wb_rd=0 with an empty scoreboard → err_underflow stays 0.
- WAW saturation (CNT_W=2):
  - Three issues to rd=7 → cnt[7]=3.
  - Fourth issue to rd=7 → issue_ready=0.
  - One wb_rd=7 → fourth issue accepted. Then three more wb needed before busy_vec[7]=0.
- Simultaneous issue and writeback:
  - cnt[9]=1. Same cycle: accept wr rd=9 and wb_rd=9 → cnt[9] stays 1, busy_vec[9]=1.
  - Bypass check, cnt[3]=1, wb_rd=3, read rs2=3 in the same cycle → issue_ready=1 with SCOREBOARD_BYPASS_EN, 0 without.
- Underflow and flush:
  - wb_rd=12 with cnt[12]=0 → err_underflow=1, stays 1 after a subsequent flush.
  - Pending on x4 and x8, assert flush with issue_valid and wb_rd=4 → issue_ready=0; next cycle busy_vec=0, no new error.
- Asynchronous reset mid-operation:
  - cnt[20]=2. Assert rst between clock edges → busy_vec=0 and err_underflow=0 immediately, without waiting for a clock edge.
